axis_round_robin_gather: RTL

Merges NUM_SLAVE_STREAMS AXI-Stream inputs into one output, one whole packet per input in strict rotating order (input 0, 1, …, N-1, 0, …). It is the receive-side counterpart of the packet-level round-robin distributor. Packets fanned out to parallel workers by the distributor come back in their original order. A 2-entry output register slice decouples `axis_o_tready` from all input `tready` lines.

---
 rtl/axis_rr_pkg.sv | 21 ++
 rtl/axis_skid_buffer.sv | 86 ++++++++
 rtl/axis_round_robin_gather.sv | 134 +++++++++++++
 3 files changed

// File: rtl/axis_rr_pkg.sv
// Shared helpers for the packet-level round-robin gather and distributor.
// sel_bits() sizes the grant pointer; next_sel() advances it with an
// explicit wrap so a non-power-of-2 stream count never reaches an
// out-of-range index.
package axis_rr_pkg;

    // Depth of the output register slice and the count value meaning "full".
    localparam int         SLICE_DEPTH    = 2;
    localparam logic [1:0] SLICE_FULL_CNT = 2'd2;

    // Width of a pointer that can name n streams; never narrower than 1 bit.
    function automatic int sel_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Next stream in rotating order: 0, 1, ..., n-1, 0, ...
    function automatic int unsigned next_sel(input int unsigned cur, input int unsigned n);
        return (cur == n - 32'd1) ? 32'd0 : cur + 32'd1;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream register slice carrying tdata and tlast.
// The upstream ready is the inverse of a registered full flag, so there is
// no combinational path from i_m_tready to o_s_tready.
//
// Handshake: a beat moves on a port when its valid and ready are both high
// at a rising clk edge; valid never depends on ready, and o_m_tdata /
// o_m_tlast stay stable while o_m_tvalid is high and i_m_tready is low.
module axis_skid_buffer
    import axis_rr_pkg::*;
#(
    parameter int AXIS_BYTES = 1
) (
    input  logic                    clk,
    input  logic                    sresetn,
    // upstream side
    input  logic                    i_s_tvalid,
    output logic                    o_s_tready,
    input  logic [AXIS_BYTES*8-1:0] i_s_tdata,
    input  logic                    i_s_tlast,
    // downstream side
    output logic                    o_m_tvalid,
    input  logic                    i_m_tready,
    output logic [AXIS_BYTES*8-1:0] o_m_tdata,
    output logic                    o_m_tlast
);

    localparam int W = AXIS_BYTES * 8;

    logic [1:0]   r_count;
    logic         r_full;
    logic [W-1:0] r_head_data;
    logic         r_head_last;
    logic [W-1:0] r_tail_data;
    logic         r_tail_last;

    logic         w_push;
    logic         w_pop;
    logic [1:0]   w_count_next;

    assign o_s_tready = !r_full;
    assign o_m_tvalid = (r_count != 2'd0);
    assign o_m_tdata  = r_head_data;
    assign o_m_tlast  = r_head_last;

    assign w_push = i_s_tvalid && !r_full;
    assign w_pop  = (r_count != 2'd0) && i_m_tready;

    // Occupancy after this edge: a simultaneous push and pop cancel out.
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + 2'd1;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - 2'd1;
        end
    end

    // Head always feeds the output; tail only holds a beat while full.
    always_ff @(posedge clk) begin
        if (!sresetn) begin
            r_count     <= 2'd0;
            r_full      <= 1'b0;
            r_head_data <= '0;
            r_head_last <= 1'b0;
            r_tail_data <= '0;
            r_tail_last <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_full  <= (w_count_next == SLICE_FULL_CNT);
            if (w_push) begin
                if (r_count == 2'd0 || (r_count == 2'd1 && w_pop)) begin
                    r_head_data <= i_s_tdata;
                    r_head_last <= i_s_tlast;
                end else begin
                    r_tail_data <= i_s_tdata;
                    r_tail_last <= i_s_tlast;
                end
            end
            if (w_pop && r_count == SLICE_FULL_CNT) begin
                r_head_data <= r_tail_data;
                r_head_last <= r_tail_last;
            end
        end
    end

endmodule

// File: rtl/axis_round_robin_gather.sv
// Packet-level round-robin gather: merges NUM_SLAVE_STREAMS AXI-Stream
// inputs into one output, one whole packet per input in rotating order
// 0, 1, ..., N-1, 0, ... so packets fanned out by the round-robin
// distributor come back in their original order.
//
// Optional build macro AXIS_RR_GATHER_SKIP_EN: work-conserving mode. While
// no packet is in flight the grant goes to the first valid input found
// scanning from sel; order preservation is then not guaranteed. Without the
// macro the order is strict and a stalled granted input stalls everything.
//
// Handshake: a beat moves on a port when its tvalid and tready are both high
// at a rising clk edge. Only the granted input ever sees tready high, and
// every tready is derived from registered state (plus the input tvalids in
// skip mode), never from axis_o_tready.
module axis_round_robin_gather
    import axis_rr_pkg::*;
#(
    parameter int AXIS_BYTES        = 1,
    parameter int NUM_SLAVE_STREAMS = 2
) (
    input  logic                                    clk,
    input  logic                                    sresetn,
    output logic [NUM_SLAVE_STREAMS-1:0]            axis_i_tready,
    input  logic [NUM_SLAVE_STREAMS-1:0]            axis_i_tvalid,
    input  logic [NUM_SLAVE_STREAMS-1:0]            axis_i_tlast,
    input  logic [NUM_SLAVE_STREAMS*AXIS_BYTES*8-1:0] axis_i_tdata,
    input  logic                                    axis_o_tready,
    output logic                                    axis_o_tvalid,
    output logic                                    axis_o_tlast,
    output logic [AXIS_BYTES*8-1:0]                 axis_o_tdata
);

    localparam int W        = AXIS_BYTES * 8;
    localparam int N        = NUM_SLAVE_STREAMS;
    localparam int SEL_BITS = sel_bits(NUM_SLAVE_STREAMS);

    logic [SEL_BITS-1:0] r_sel;
    logic [SEL_BITS-1:0] w_grant;
    logic                w_grant_vld;
    logic                w_in_valid;
    logic                w_in_last;
    logic [W-1:0]        w_in_data;
    logic                w_slice_ready;
    logic                w_accept;

`ifdef AXIS_RR_GATHER_SKIP_EN
    logic r_in_packet;

    // Mid-packet the grant is locked to sel; otherwise pick the first valid
    // input at offset 0, 1, ... from sel (scanned high to low so the
    // smallest offset wins).
    always_comb begin
        w_grant     = r_sel;
        w_grant_vld = r_in_packet;
        if (!r_in_packet) begin
            for (int off = N - 1; off >= 0; off--) begin
                for (int k = 0; k < N; k++) begin
                    if (k == (int'(r_sel) + off) % N && axis_i_tvalid[k]) begin
                        w_grant     = SEL_BITS'(k);
                        w_grant_vld = 1'b1;
                    end
                end
            end
        end
    end

    // First beat locks sel to the granted input; tlast releases the lock and
    // moves the scan start just past the input that was served.
    always_ff @(posedge clk) begin
        if (!sresetn) begin
            r_sel       <= '0;
            r_in_packet <= 1'b0;
        end else if (w_accept) begin
            if (w_in_last) begin
                r_in_packet <= 1'b0;
                r_sel       <= SEL_BITS'(next_sel(32'(w_grant), N));
            end else begin
                r_in_packet <= 1'b1;
                r_sel       <= w_grant;
            end
        end
    end
`else
    // Strict order: the grant is always the sel input, whatever the tvalids.
    always_comb begin
        w_grant     = r_sel;
        w_grant_vld = 1'b1;
    end

    // Advance to the next input only once a whole packet has been taken.
    always_ff @(posedge clk) begin
        if (!sresetn) begin
            r_sel <= '0;
        end else if (w_accept && w_in_last) begin
            r_sel <= SEL_BITS'(next_sel(32'(r_sel), N));
        end
    end
`endif

    // Route the granted input to the slice and raise only its tready; the
    // reset term keeps every tready low while sresetn is asserted.
    always_comb begin
        w_in_valid    = 1'b0;
        w_in_last     = 1'b0;
        w_in_data     = '0;
        axis_i_tready = '0;
        for (int k = 0; k < N; k++) begin
            if (w_grant == SEL_BITS'(k)) begin
                w_in_valid       = axis_i_tvalid[k];
                w_in_last        = axis_i_tlast[k];
                w_in_data        = axis_i_tdata[k*W +: W];
                axis_i_tready[k] = w_grant_vld && w_slice_ready && sresetn;
            end
        end
    end

    assign w_accept = w_grant_vld && w_in_valid && w_slice_ready && sresetn;

    axis_skid_buffer #(
        .AXIS_BYTES (AXIS_BYTES)
    ) u_slice (
        .clk        (clk),
        .sresetn    (sresetn),
        .i_s_tvalid (w_accept),
        .o_s_tready (w_slice_ready),
        .i_s_tdata  (w_in_data),
        .i_s_tlast  (w_in_last),
        .o_m_tvalid (axis_o_tvalid),
        .i_m_tready (axis_o_tready),
        .o_m_tdata  (axis_o_tdata),
        .o_m_tlast  (axis_o_tlast)
    );

endmodule
